// File: rtl/text_buffer_ctrl_pkg.sv
// rtl/text_buffer_ctrl_pkg.sv - shared constants and state type for the text buffer writer
package text_buffer_ctrl_pkg;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_FF    = 8'h0C;

   typedef enum logic [1:0] {
      CLR_ALL = 2'd0,
      IDLE    = 2'd1,
      CLR_ROW = 2'd2
   } state_e;

endpackage

// File: rtl/text_buffer_ctrl_cursor.sv
// rtl/text_buffer_ctrl_cursor.sv - cursor row/col register with wrap and row-advance flag
module text_cursor #(
   parameter int ROWS = 4,
   parameter int COLS = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      home_i,
   input  logic                      inc_i,
   input  logic                      dec_i,
   input  logic                      cr_i,
   input  logic                      lf_i,
   output logic [$clog2(ROWS)-1:0]   row_o,
   output logic [$clog2(COLS)-1:0]   col_o,
   output logic                      row_adv_o
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          row_adv;

   // Next cursor position; row_adv tells the top a new row must be cleared.
   always_comb begin
      row_d   = row_q;
      col_d   = col_q;
      row_adv = 1'b0;
      if (home_i) begin
         row_d = '0;
         col_d = '0;
      end else if (lf_i) begin
         col_d   = '0;
         row_adv = 1'b1;
      end else if (cr_i) begin
         col_d = '0;
      end else if (inc_i) begin
         if (col_q == CW'(COLS - 1)) begin
            col_d   = '0;
            row_adv = 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end else if (dec_i) begin
         if (col_q != '0) begin
            col_d = col_q - 1'b1;
         end else if (row_q != '0) begin
            row_d = row_q - 1'b1;
            col_d = CW'(COLS - 1);
         end
      end
      if (row_adv) begin
         row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end
   end

   // Cursor register; reset homes the cursor.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o     = row_q;
   assign col_o     = col_q;
   assign row_adv_o = row_adv;

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - write-side sequencer for the character RAM
module text_buffer_ctrl
   import text_buffer_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 4,
   parameter int COLS       = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      in_ready,
   output logic                      ram_we,
   output logic [$clog2(ROWS)-1:0]   ram_w_row,
   output logic [$clog2(COLS)-1:0]   ram_w_col,
   output logic [DATA_WIDTH-1:0]     ram_din,
   output logic [$clog2(ROWS)-1:0]   cur_row,
   output logic [$clog2(COLS)-1:0]   cur_col,
   output logic                      busy
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [DATA_WIDTH-1:0] SPACE = DATA_WIDTH'(CH_SPACE);

   state_e                state_q, state_d;
   logic [RW-1:0]         clr_row_q, clr_row_d;
   logic [CW-1:0]         clr_col_q, clr_col_d;
   logic                  ram_we_q, ram_we_d;
   logic [RW-1:0]         ram_w_row_q, ram_w_row_d;
   logic [CW-1:0]         ram_w_col_q, ram_w_col_d;
   logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
   logic                  in_ready_q, in_ready_d;
   logic                  busy_q, busy_d;

   logic                  home_c, inc_c, dec_c, cr_c, lf_c;
   logic                  row_adv;
   logic                  accept;
   logic                  printable;

   text_cursor #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_cursor (
      .clk       (clk),
      .rst_n     (rst_n),
      .home_i    (home_c),
      .inc_i     (inc_c),
      .dec_i     (dec_c),
      .cr_i      (cr_c),
      .lf_i      (lf_c),
      .row_o     (cur_row),
      .col_o     (cur_col),
      .row_adv_o (row_adv)
   );

   assign accept    = in_valid && in_ready_q && (state_q == IDLE);
   assign printable = (in_data >= DATA_WIDTH'(CH_SPACE)) && (in_data <= DATA_WIDTH'(CH_TILDE));

   // Next state, clear counters, registered RAM write port and byte decode.
   always_comb begin
      state_d     = state_q;
      clr_row_d   = clr_row_q;
      clr_col_d   = clr_col_q;
      ram_we_d    = 1'b0;
      ram_w_row_d = ram_w_row_q;
      ram_w_col_d = ram_w_col_q;
      ram_din_d   = ram_din_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      home_c      = 1'b0;
      inc_c       = 1'b0;
      dec_c       = 1'b0;
      cr_c        = 1'b0;
      lf_c        = 1'b0;

      case (state_q)
         CLR_ALL: begin
            ram_we_d    = 1'b1;
            ram_w_row_d = clr_row_q;
            ram_w_col_d = clr_col_q;
            ram_din_d   = SPACE;
            in_ready_d  = 1'b0;
            busy_d      = 1'b1;
            if (clr_col_q == CW'(COLS - 1)) begin
               clr_col_d = '0;
               if (clr_row_q == RW'(ROWS - 1)) begin
                  clr_row_d  = '0;
                  state_d    = IDLE;
                  in_ready_d = 1'b1;
                  busy_d     = 1'b0;
               end else begin
                  clr_row_d = clr_row_q + 1'b1;
               end
            end else begin
               clr_col_d = clr_col_q + 1'b1;
            end
         end

         IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            if (accept) begin
               if (printable) begin
                  ram_we_d    = 1'b1;
                  ram_w_row_d = cur_row;
                  ram_w_col_d = cur_col;
                  ram_din_d   = in_data;
                  inc_c       = 1'b1;
               end else if (in_data == DATA_WIDTH'(CH_CR)) begin
                  cr_c = 1'b1;
               end else if (in_data == DATA_WIDTH'(CH_LF)) begin
                  lf_c = 1'b1;
               end else if (in_data == DATA_WIDTH'(CH_BS)) begin
                  dec_c = 1'b1;
                  if (cur_col != '0) begin
                     ram_we_d    = 1'b1;
                     ram_w_row_d = cur_row;
                     ram_w_col_d = cur_col - 1'b1;
                     ram_din_d   = SPACE;
                  end
               end else if (in_data == DATA_WIDTH'(CH_FF)) begin
                  home_c     = 1'b1;
                  clr_row_d  = '0;
                  clr_col_d  = '0;
                  state_d    = CLR_ALL;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
               end
               // A new row may hold stale text, so it is wiped before more input.
               if (row_adv) begin
                  clr_col_d  = '0;
                  state_d    = CLR_ROW;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
               end
            end
         end

         CLR_ROW: begin
            ram_we_d    = 1'b1;
            ram_w_row_d = cur_row;
            ram_w_col_d = clr_col_q;
            ram_din_d   = SPACE;
            in_ready_d  = 1'b0;
            busy_d      = 1'b1;
            if (clr_col_q == CW'(COLS - 1)) begin
               clr_col_d  = '0;
               state_d    = IDLE;
               in_ready_d = 1'b1;
               busy_d     = 1'b0;
            end else begin
               clr_col_d = clr_col_q + 1'b1;
            end
         end

         default: begin
            state_d = CLR_ALL;
         end
      endcase
   end

   // State and output registers; reset restarts the full clear from (0,0).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= CLR_ALL;
         clr_row_q   <= '0;
         clr_col_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_w_row_q <= '0;
         ram_w_col_q <= '0;
         ram_din_q   <= SPACE;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         clr_row_q   <= clr_row_d;
         clr_col_q   <= clr_col_d;
         ram_we_q    <= ram_we_d;
         ram_w_row_q <= ram_w_row_d;
         ram_w_col_q <= ram_w_col_d;
         ram_din_q   <= ram_din_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign ram_we    = ram_we_q;
   assign ram_w_row = ram_w_row_q;
   assign ram_w_col = ram_w_col_q;
   assign ram_din   = ram_din_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - directed self-checking bench for text_buffer_ctrl
module tb_text_buffer_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       ram_we;
   logic [1:0] ram_w_row;
   logic [4:0] ram_w_col;
   logic [7:0] ram_din;
   logic [1:0] cur_row;
   logic [4:0] cur_col;
   logic       busy;

   text_buffer_ctrl #(
      .DATA_WIDTH (8),
      .ROWS       (4),
      .COLS       (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .ram_we    (ram_we),
      .ram_w_row (ram_w_row),
      .ram_w_col (ram_w_col),
      .ram_din   (ram_din),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_vec;
   int         n_bad;
   int         wr_cnt;
   int         sp_cnt;
   logic [1:0] first_row, last_row;
   logic [4:0] first_col, last_col;
   logic [7:0] last_din;
   logic [7:0] model [4][32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and log any RAM write seen there.
   task automatic tick();
      @(negedge clk);
      if (ram_we) begin
         if (wr_cnt == 0) begin
            first_row = ram_w_row;
            first_col = ram_w_col;
         end
         model[ram_w_row][ram_w_col] = ram_din;
         wr_cnt++;
         if (ram_din == 8'h20) sp_cnt++;
         last_row = ram_w_row;
         last_col = ram_w_col;
         last_din = ram_din;
      end
   endtask

   task automatic clear_log();
      wr_cnt = 0;
      sp_cnt = 0;
   endtask

   // Present a byte, hold it until in_ready, return at the edge after acceptance.
   task automatic send(input logic [7:0] b);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 3000) begin
         tick();
         n++;
      end
      chk(tag, 32'(in_ready), 32'd1);
   endtask

   task automatic chk_cur(input string tag, input int r, input int c);
      chk(tag, {25'd0, cur_row, cur_col}, 32'((r << 5) | c));
   endtask

   initial begin
      int n;
      int c0;
      n_vec    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clear_log();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 32; c++)
            model[r][c] = 8'hFF;

      // 1: reset values, then the 128-cycle power-up clear
      tick();
      tick();
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_din", 32'(ram_din), 32'h20);
      chk("rst_addr", {25'd0, ram_w_row, ram_w_col}, 32'd0);
      chk_cur("rst_cur", 0, 0);
      clear_log();
      rst_n = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      chk("clr_cycles", 32'(n), 32'd128);
      chk("clr_writes", 32'(wr_cnt), 32'd128);
      chk("clr_spaces", 32'(sp_cnt), 32'd128);
      chk("clr_first", {25'd0, first_row, first_col}, 32'd0);
      chk("clr_last", {25'd0, last_row, last_col}, 32'((3 << 5) | 31));
      chk("clr_busy", 32'(busy), 32'd0);
      chk_cur("clr_cur", 0, 0);

      // 2: "AB"
      clear_log();
      send(8'h41);
      chk("a_addr", {25'd0, last_row, last_col}, 32'd0);
      chk("a_din", 32'(last_din), 32'h41);
      send(8'h42);
      chk("b_addr", {25'd0, last_row, last_col}, 32'd1);
      chk("b_din", 32'(last_din), 32'h42);
      chk("ab_writes", 32'(wr_cnt), 32'd2);
      chk_cur("ab_cur", 0, 2);

      // 3: CR then 32 x 'x' wraps into a row-1 clear
      clear_log();
      send(8'h0D);
      tick();
      chk("cr_nowrite", 32'(wr_cnt), 32'd0);
      chk_cur("cr_cur", 0, 0);
      for (int i = 0; i < 32; i++) send(8'h78);
      chk("wrap_addr", {25'd0, last_row, last_col}, 32'd31);
      chk("wrap_din", 32'(last_din), 32'h78);
      chk("wrap_busy", 32'(busy), 32'd1);
      chk("wrap_ready", 32'(in_ready), 32'd0);
      chk_cur("wrap_cur", 1, 0);
      clear_log();
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      chk("row1_cycles", 32'(n), 32'd32);
      chk("row1_spaces", 32'(sp_cnt), 32'd32);
      chk("row1_last", {25'd0, last_row, last_col}, 32'((1 << 5) | 31));

      // 4: fill to (3,5), LF wraps to row 0 while the next byte is held
      send(8'h0A);
      wait_idle("lf2_idle");
      send(8'h0A);
      wait_idle("lf3_idle");
      send(8'h68); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
      chk_cur("hello_cur", 3, 5);
      chk("hello_model", 32'(model[3][4]), 32'h6F);
      clear_log();
      send(8'h0A);
      chk_cur("lfwrap_cur", 0, 0);
      chk("lfwrap_busy", 32'(busy), 32'd1);
      send(8'h5A);
      chk("held_writes", 32'(wr_cnt), 32'd33);
      chk("held_spaces", 32'(sp_cnt), 32'd32);
      chk("held_addr", {25'd0, last_row, last_col}, 32'd0);
      chk("held_din", 32'(last_din), 32'h5A);
      chk("stale_gone", 32'(model[0][31]), 32'h20);
      chk_cur("held_cur", 0, 1);
      tick();
      tick();
      chk("no_double", 32'(wr_cnt), 32'd33);
      chk_cur("no_double_cur", 0, 1);

      // 5: backspace cases, CR, dropped byte
      send(8'h0A);
      wait_idle("lf1_idle");
      chk_cur("lf1_cur", 1, 0);
      c0 = wr_cnt;
      send(8'h08);
      tick();
      chk("bs_row_nowrite", 32'(wr_cnt), 32'(c0));
      chk_cur("bs_row_cur", 0, 31);
      send(8'h0D);
      send(8'h61); send(8'h62); send(8'h63);
      chk_cur("abc_cur", 0, 3);
      c0 = wr_cnt;
      send(8'h08);
      chk("bs_write", 32'(wr_cnt), 32'(c0 + 1));
      chk("bs_addr", {25'd0, last_row, last_col}, 32'd2);
      chk("bs_din", 32'(last_din), 32'h20);
      chk_cur("bs_cur", 0, 2);
      c0 = wr_cnt;
      send(8'h0D);
      tick();
      chk("cr2_nowrite", 32'(wr_cnt), 32'(c0));
      chk_cur("cr2_cur", 0, 0);
      send(8'h08);
      send(8'h7F);
      tick();
      chk("bs00_nowrite", 32'(wr_cnt), 32'(c0));
      chk_cur("bs00_cur", 0, 0);
      chk("drop_ready", 32'(in_ready), 32'd1);

      // 6: FF, then reset in the middle of the clear
      send(8'h61);
      send(8'h0C);
      chk("ff_busy", 32'(busy), 32'd1);
      chk("ff_ready", 32'(in_ready), 32'd0);
      chk_cur("ff_cur", 0, 0);
      clear_log();
      repeat (50) tick();
      chk("ff_writes", 32'(wr_cnt), 32'd50);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_we", 32'(ram_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      clear_log();
      rst_n = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      chk("reclr_cycles", 32'(n), 32'd128);
      chk("reclr_spaces", 32'(sp_cnt), 32'd128);
      chk("reclr_first", {25'd0, first_row, first_col}, 32'd0);
      chk("reclr_last", {25'd0, last_row, last_col}, 32'((3 << 5) | 31));
      chk_cur("reclr_cur", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
